cpu_io_handshake_ctrl: RTL and testbench

//  CPU-side initiator for the four-phase req/ack I/O handshake. Sits between the CPU control unit and
//  the input/output responder units. Turns a one-cycle start pulse into a full request/acknowledge

---
 rtl/cpu_io_handshake_ctrl.sv | 158 +++++++++++++++
 tb/tb_cpu_io_handshake_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_handshake_ctrl.sv
// cpu_io_handshake_ctrl: CPU-side initiator for the four-phase req/ack input/output handshake.
// Optional per-phase timeout abort is built when the IO_TIMEOUT_EN macro is defined.
module cpu_io_handshake_ctrl #(
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          in_start,
  input  logic          out_start,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          inp_req,
  input  logic          inp_ack,
  input  logic [DW-1:0] inp_data,
  output logic          out_req,
  input  logic          out_ack,
  output logic [DW-1:0] out_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IN_REQ  = 3'd1,
    IN_REL  = 3'd2,
    OUT_REQ = 3'd3,
    OUT_REL = 3'd4
  } state_t;

  state_t state;
  logic   advance;
  logic   timeout_hit;

  // A phase timeout shorter than two cycles could never let a handshake complete.
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("cpu_io_handshake_ctrl: TIMEOUT must be at least 2");
  end

  // The ack edge each waiting phase is looking for.
  always_comb begin
    advance = 1'b0;
    case (state)
      IN_REQ:  advance = inp_ack;
      IN_REL:  advance = ~inp_ack;
      OUT_REQ: advance = out_ack;
      OUT_REL: advance = ~out_ack;
      default: advance = 1'b0;
    endcase
  end

`ifdef IO_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // The awaited ack edge always takes priority over an expiring count.
  assign timeout_hit = (state != IDLE) && !advance && (cnt == CW'(TIMEOUT - 1));

  // Phase-age counter: restarts whenever the FSM changes state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if ((state == IDLE) || advance || timeout_hit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Handshake sequencer; every output is a flop so the responders see clean levels.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      rdata    <= '0;
      out_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      inp_req  <= 1'b0;
      out_req  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_start) begin
            state   <= IN_REQ;
            inp_req <= 1'b1;
            busy    <= 1'b1;
          end else if (out_start) begin
            state    <= OUT_REQ;
            out_data <= wdata;
            out_req  <= 1'b1;
            busy     <= 1'b1;
          end
        end

        IN_REQ: begin
          if (advance) begin
            state   <= IN_REL;
            rdata   <= inp_data;
            inp_req <= 1'b0;
          end else if (timeout_hit) begin
            state   <= IDLE;
            inp_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end
        end

        IN_REL: begin
          if (advance || timeout_hit) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= timeout_hit;
          end
        end

        OUT_REQ: begin
          if (advance) begin
            state   <= OUT_REL;
            out_req <= 1'b0;
          end else if (timeout_hit) begin
            state   <= IDLE;
            out_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end
        end

        OUT_REL: begin
          if (advance || timeout_hit) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= timeout_hit;
          end
        end

        default: begin
          state   <= IDLE;
          inp_req <= 1'b0;
          out_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_io_handshake_ctrl.sv
// Randomized scoreboard bench for cpu_io_handshake_ctrl with behavioural input/output responders.
// Build with IO_TIMEOUT_EN defined to exercise the abort path (TIMEOUT=8).
module tb_cpu_io_handshake_ctrl;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          in_start = 1'b0;
  logic          out_start = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;
  logic          err;
  logic          inp_req;
  logic          inp_ack = 1'b0;
  logic [DW-1:0] inp_data = '0;
  logic          out_req;
  logic          out_ack = 1'b0;
  logic [DW-1:0] out_data;

  cpu_io_handshake_ctrl #(.DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst_b(rst_b), .in_start(in_start), .out_start(out_start), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err), .inp_req(inp_req), .inp_ack(inp_ack),
    .inp_data(inp_data), .out_req(out_req), .out_ack(out_ack), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_out;
    logic [DW-1:0] data;
    bit            err;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] exp_out = '0;
  logic [DW-1:0] exp_rdata = '0;
  int            n_tests = 0;
  int            n_fail = 0;
  bit            in_resp_en = 1'b0;
  bit            out_resp_en = 1'b0;
  int            in_d1 = 0, in_d2 = 0, out_d1 = 0, out_d2 = 0;
  logic [DW-1:0] in_word = '0;
  bit            prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Input responder: ack after in_d1 cycles, release in_d2 cycles after req falls.
  initial begin
    forever begin
      step();
      if (in_resp_en && rst_b && inp_req && !inp_ack) begin
        repeat (in_d1) step();
        inp_ack  = 1'b1;
        inp_data = in_word;
        while (inp_req) step();
        repeat (in_d2) step();
        inp_ack  = 1'b0;
        inp_data = DW'($urandom);
      end
    end
  end

  // Output responder; also checks that out_req drops exactly one cycle after ack is seen.
  initial begin
    forever begin
      step();
      if (out_resp_en && rst_b && out_req && !out_ack) begin
        repeat (out_d1) step();
        out_ack = 1'b1;
        @(negedge clk);
        check("out_req_held_until_ack_sampled", 32'(out_req), 32'd1);
        @(negedge clk);
        check("out_req_drop_after_ack", 32'(out_req), 32'd0);
        while (out_req) step();
        repeat (out_d2) step();
        out_ack = 1'b0;
      end
    end
  end

  // Monitor: out_data hold every cycle, and scoreboard pop on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        check("out_data_hold", 32'(out_data), 32'(exp_out));
        if (done) begin
          check("done_single_pulse", 32'(prev_done), 32'd0);
          check("busy_low_at_done", 32'(busy), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            if (e.is_out) check("out_data_at_done", 32'(out_data), 32'(e.data));
            else          check("rdata_at_done", 32'(rdata), 32'(e.data));
            check("err_at_done", 32'(err), 32'(e.err));
          end
        end
      end
      prev_done = done;
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      step();
      wdata = DW'($urandom);
      n++;
    end
    if (busy) begin
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, n);
      $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
      $fatal(1, "handshake stuck");
    end
  endtask

  task automatic do_txn(input bit is_out, input logic [DW-1:0] word, input int d1,
                        input int d2, input bit poke);
    step();
    if (is_out) begin
      out_d1 = d1; out_d2 = d2;
      wdata = word; out_start = 1'b1;
    end else begin
      in_d1 = d1; in_d2 = d2; in_word = word;
      in_start = 1'b1;
    end
    exp_q.push_back('{is_out: is_out, data: word, err: 1'b0});
    step();
    in_start = 1'b0; out_start = 1'b0;
    wdata = DW'($urandom);
    if (is_out) exp_out = word;
    else        exp_rdata = word;
    @(negedge clk);
    check(is_out ? "out_req_latency" : "inp_req_latency",
          32'(is_out ? out_req : inp_req), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
    if (poke) begin
      step();
      out_start = 1'b1;
      wdata = DW'($urandom);
      step();
      out_start = 1'b0;
      @(negedge clk);
      check("out_start_ignored_when_busy", 32'(out_req), 32'd0);
    end
    wait_idle("txn_complete");
  endtask

  task automatic apply_reset();
    step(); #1;
    rst_b = 1'b0;
    exp_out = '0;
    exp_rdata = '0;
    exp_q.delete();
    #1;
    check("reset_async_outputs", 32'({out_req, inp_req, busy, done, err}), 32'd0);
    check("reset_data", 32'({rdata, out_data}), 32'd0);
    repeat (2) step();
    rst_b = 1'b1;
  endtask

  initial begin
    // Reset with the ack/data lines toggling randomly.
    for (int i = 0; i < 6; i++) begin
      step();
      inp_ack = 1'($urandom); out_ack = 1'($urandom);
      inp_data = DW'($urandom); wdata = DW'($urandom);
      @(negedge clk);
      check("reset_hold_outputs",
            32'({out_req, inp_req, busy, done, err}), 32'd0);
      check("reset_hold_data", 32'({rdata, out_data}), 32'd0);
    end
    step();
    inp_ack = 1'b0; out_ack = 1'b0;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 32'({busy, inp_req, out_req, done}), 32'd0);
    in_resp_en = 1'b1;
    out_resp_en = 1'b1;

    // Directed input and output transactions; an output start during the input is ignored.
    do_txn(1'b0, 16'hA5A5, 3, 2, 1'b1);
    check("rdata_a5a5", 32'(rdata), 32'h0000_A5A5);
    do_txn(1'b1, 16'h1234, 2, 2, 1'b0);
    check("out_data_1234", 32'(out_data), 32'h0000_1234);
    do_txn(1'b1, 16'h0F0F, 0, 0, 1'b0);
    do_txn(1'b0, 16'hFFFF, 0, 0, 1'b0);

    // Collision: input wins, out_start dropped.
    step();
    in_d1 = 1; in_d2 = 1; in_word = 16'h5A5A;
    in_start = 1'b1; out_start = 1'b1; wdata = 16'hDEAD;
    exp_q.push_back('{is_out: 1'b0, data: 16'h5A5A, err: 1'b0});
    step();
    in_start = 1'b0; out_start = 1'b0;
    exp_rdata = 16'h5A5A;
    @(negedge clk);
    check("collision_inp_req", 32'(inp_req), 32'd1);
    check("collision_out_req", 32'(out_req), 32'd0);
    wait_idle("collision_complete");

    // Input with no acknowledge at all.
    in_resp_en = 1'b0;
    step();
    in_start = 1'b1;
`ifdef IO_TIMEOUT_EN
    exp_q.push_back('{is_out: 1'b0, data: exp_rdata, err: 1'b1});
`endif
    step();
    in_start = 1'b0;
`ifdef IO_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("timeout_waiting", 32'({inp_req, done}), 32'b10);
    end
    @(negedge clk);
    check("timeout_abort", 32'({inp_req, done, err}), 32'b011);
    check("timeout_rdata_kept", 32'(rdata), 32'(exp_rdata));
`else
    repeat (20) @(negedge clk);
    check("no_timeout_busy_held", 32'({busy, inp_req}), 32'b11);
    apply_reset();
`endif
    in_resp_en = 1'b1;

    // Reset while the output handshake waits for ack to fall.
    step();
    out_d1 = 1; out_d2 = 8;
    wdata = 16'hBEEF; out_start = 1'b1;
    step();
    out_start = 1'b0;
    exp_out = 16'hBEEF;
    for (int n = 0; n < 50 && !(out_ack && !out_req); n++) step();
    check("reached_out_rel", 32'({out_ack, out_req}), 32'b10);
    apply_reset();
    for (int n = 0; n < 50 && out_ack; n++) step();
    check("ack_released_after_reset", 32'(out_ack), 32'd0);
    do_txn(1'b1, 16'hC3C3, 1, 1, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom), DW'($urandom), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 4)), 1'b0);
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (4) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("final_rdata", 32'(rdata), 32'(exp_rdata));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
